// File: rtl/cache_mshr_pkg.sv
// rtl/cache_mshr_pkg.sv - shared types and default sizes for the miss-status holding registers
package cache_mshr_pkg;

  localparam int PA_BITS_DEF   = 56;
  localparam int OFFSETLEN_DEF = 6;
  localparam int NUMMSHR_DEF   = 4;

  typedef enum logic [1:0] {
    INVALID = 2'd0,
    PENDING = 2'd1,
    ISSUED  = 2'd2,
    FILLED  = 2'd3
  } mshr_state_t;

endpackage

// File: rtl/cache_mshr_entry.sv
// rtl/cache_mshr_entry.sv - one MSHR entry: state, line address, dirty/cancel flags and match logic
module cache_mshr_entry
  import cache_mshr_pkg::*;
#(
  parameter int LA = 50
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          alloc,
  input  logic          merge,
  input  logic          allocWrite,
  input  logic [LA-1:0] allocAdr,
  input  logic          issue,
  input  logic          fill,
  input  logic          retire,
  input  logic          invalidate,
  input  logic [LA-1:0] lookupAdr,
  output mshr_state_t   state,
  output logic [LA-1:0] adr,
  output logic          dirty,
  output logic          cancel,
  output logic          match,
  output logic          lookupHit
);

  mshr_state_t   stateNext;
  logic [LA-1:0] adrNext;
  logic          dirtyNext;
  logic          cancelNext;

  // Cancelled entries and an entry retiring this cycle are not merge targets,
  // so a new request for the same line gets a fresh entry that will be filled.
  always_comb begin
    match     = (state != INVALID) && !cancel && !retire && (adr == allocAdr);
    lookupHit = (state != INVALID) && (adr == lookupAdr);
  end

  // Next-state: invalidate overrides issue; an ISSUED fill in the same cycle lands cancelled.
  always_comb begin
    stateNext  = state;
    adrNext    = adr;
    dirtyNext  = dirty;
    cancelNext = cancel;
    case (state)
      INVALID: begin
        if (alloc) begin
          stateNext  = PENDING;
          adrNext    = allocAdr;
          dirtyNext  = allocWrite;
          cancelNext = 1'b0;
        end
      end
      PENDING: begin
        if (invalidate) stateNext = INVALID;
        else if (issue) stateNext = ISSUED;
      end
      ISSUED: begin
        if (invalidate) cancelNext = 1'b1;
        if (fill)       stateNext  = FILLED;
      end
      FILLED: begin
        if (invalidate || cancel || retire) begin
          stateNext  = INVALID;
          dirtyNext  = 1'b0;
          cancelNext = 1'b0;
        end
      end
      default: stateNext = INVALID;
    endcase
    if (merge && (state != INVALID)) dirtyNext = dirty | allocWrite;
  end

  // State register with asynchronous abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= INVALID;
      adr    <= '0;
      dirty  <= 1'b0;
      cancel <= 1'b0;
    end else begin
      state  <= stateNext;
      adr    <= adrNext;
      dirty  <= dirtyNext;
      cancel <= cancelNext;
    end
  end

endmodule

// File: rtl/cache_mshr.sv
// rtl/cache_mshr.sv - MSHR file: alloc/merge, bus issue and retire priority selection
module cache_mshr
  import cache_mshr_pkg::*;
#(
  parameter int PA_BITS   = PA_BITS_DEF,
  parameter int OFFSETLEN = OFFSETLEN_DEF,
  parameter int NUMMSHR   = NUMMSHR_DEF,
  localparam int LA       = PA_BITS - OFFSETLEN,
  localparam int IDX      = $clog2(NUMMSHR)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           AllocValid,
  input  logic [LA-1:0]  AllocAdr,
  input  logic           AllocWrite,
  input  logic           FlushStage,
  output logic           AllocReady,
  output logic [IDX-1:0] AllocIdx,
  output logic           MergeHit,
  output logic           Full,
  input  logic [LA-1:0]  LookupAdr,
  output logic           LookupHit,
  output logic           BusReqValid,
  input  logic           BusReqReady,
  output logic [LA-1:0]  BusReqAdr,
  output logic [IDX-1:0] BusReqIdx,
  input  logic           FillDone,
  input  logic [IDX-1:0] FillIdx,
  output logic           RetireValid,
  input  logic           RetireReady,
  output logic [IDX-1:0] RetireIdx,
  output logic [LA-1:0]  RetireAdr,
  output logic           RetireDirty,
  input  logic           InvalidateMshr,
  output logic           ProtocolErr
);

  mshr_state_t        entState [NUMMSHR];
  logic [LA-1:0]      entAdr   [NUMMSHR];
  logic [NUMMSHR-1:0] entDirty, entCancel, entMatch, entLookup;
  logic [NUMMSHR-1:0] invalidVec, pendingVec, readyVec;
  logic [NUMMSHR-1:0] allocVec, mergeVec, issueVec, fillVec, retireVec;
  logic [IDX-1:0]     freeIdx, matchIdx, issueIdx, retireIdx;
  logic               allocGo, anyMatch, fillOk;

  for (genvar i = 0; i < NUMMSHR; i++) begin : gEntry
    cache_mshr_entry #(.LA(LA)) uEntry (
      .clk(clk), .reset_n(reset_n),
      .alloc(allocVec[i]), .merge(mergeVec[i]), .allocWrite(AllocWrite), .allocAdr(AllocAdr),
      .issue(issueVec[i]), .fill(fillVec[i]), .retire(retireVec[i]), .invalidate(InvalidateMshr),
      .lookupAdr(LookupAdr), .state(entState[i]), .adr(entAdr[i]), .dirty(entDirty[i]),
      .cancel(entCancel[i]), .match(entMatch[i]), .lookupHit(entLookup[i])
    );
  end

  // Per-entry status and lowest-index selection for issue and retire.
  always_comb begin
    issueIdx  = '0;
    retireIdx = '0;
    for (int i = 0; i < NUMMSHR; i++) begin
      invalidVec[i] = (entState[i] == INVALID);
      pendingVec[i] = (entState[i] == PENDING);
      readyVec[i]   = (entState[i] == FILLED) && !entCancel[i];
    end
    for (int i = NUMMSHR - 1; i >= 0; i--) begin
      if (pendingVec[i]) issueIdx  = IDX'(i);
      if (readyVec[i])   retireIdx = IDX'(i);
    end
  end

  // Handshake strobes into the selected entries; fills only count on ISSUED entries.
  always_comb begin
    fillOk = FillDone && (entState[FillIdx] == ISSUED);
    for (int i = 0; i < NUMMSHR; i++) begin
      issueVec[i]  = BusReqValid && BusReqReady && (issueIdx == IDX'(i));
      retireVec[i] = RetireValid && RetireReady && (retireIdx == IDX'(i));
      fillVec[i]   = fillOk && (FillIdx == IDX'(i));
    end
  end

  // Allocation: merge into a matching entry, otherwise take the lowest INVALID one.
  always_comb begin
    allocGo  = AllocValid && !FlushStage && !InvalidateMshr;
    anyMatch = |entMatch;
    freeIdx  = '0;
    matchIdx = '0;
    for (int i = NUMMSHR - 1; i >= 0; i--) begin
      if (invalidVec[i]) freeIdx  = IDX'(i);
      if (entMatch[i])   matchIdx = IDX'(i);
    end
    for (int i = 0; i < NUMMSHR; i++) begin
      allocVec[i] = allocGo && !anyMatch && (invalidVec != '0) && (freeIdx == IDX'(i));
      mergeVec[i] = allocGo && anyMatch && (matchIdx == IDX'(i));
    end
  end

  assign Full        = ~|invalidVec;
  assign MergeHit    = allocGo && anyMatch;
  assign AllocReady  = allocGo && (anyMatch || !Full);
  assign AllocIdx    = anyMatch ? matchIdx : freeIdx;
  assign LookupHit   = |entLookup;
  assign BusReqValid = |pendingVec;
  assign BusReqIdx   = issueIdx;
  assign BusReqAdr   = entAdr[issueIdx];
  assign RetireValid = |readyVec;
  assign RetireIdx   = retireIdx;
  assign RetireAdr   = entAdr[retireIdx];
  assign RetireDirty = entDirty[retireIdx];

  // Sticky flag for a fill aimed at an entry that has no outstanding request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 ProtocolErr <= 1'b0;
    else if (FillDone && !fillOk) ProtocolErr <= 1'b1;
  end

endmodule
